// File: rtl/saturn_pkg.sv
// rtl/saturn_pkg.sv - shared instruction classes, opcode nibbles and framer states
package saturn_pkg;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RTN,
    CLS_MODE,
    CLS_RSTK,
    CLS_PTR,
    CLS_LC,
    CLS_JUMP,
    CLS_EXT
  } ins_class_e;

  typedef enum logic [1:0] {
    S_FIRST,
    S_COLLECT,
    S_ERR
  } frm_state_e;

  localparam logic [3:0] OP_BLK0  = 4'h0;
  localparam logic [3:0] OP_P     = 4'h2;
  localparam logic [3:0] OP_LC    = 4'h3;
  localparam logic [3:0] OP_GOTO  = 4'h6;
  localparam logic [3:0] OP_GOSUB = 4'h7;
  localparam logic [3:0] OP_EXT   = 4'hE;

endpackage

// File: rtl/saturn_ins_len.sv
// rtl/saturn_ins_len.sv - instruction length/class decode from the first two nibbles
// Length is 0 while it still depends on a second nibble that has not arrived.
module saturn_ins_len
  import saturn_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic [3:0]       i_n0,
  input  logic [3:0]       i_n1,
  input  logic             i_have_n1,
  output logic [LEN_W-1:0] o_len,
  output ins_class_e       o_class,
  output logic             o_illegal
);

  always_comb begin
    o_len     = '0;
    o_class   = CLS_NONE;
    o_illegal = 1'b0;
    case (i_n0)
      OP_BLK0: begin
        if (i_have_n1) begin
          if (!i_n1[3]) begin
            o_len   = LEN_W'(2);
            // 0-3 returns, 4-5 SETHEX/SETDEC, 6-7 return stack moves
            o_class = i_n1[2] ? (i_n1[1] ? CLS_RSTK : CLS_MODE) : CLS_RTN;
          end else if (i_n1 == OP_EXT) begin
            o_len   = LEN_W'(4);
            o_class = CLS_EXT;
          end else begin
            o_illegal = 1'b1;
          end
        end
      end
      OP_P: begin
        o_len   = LEN_W'(2);
        o_class = CLS_PTR;
      end
      OP_LC: begin
        o_class = CLS_LC;
        if (i_have_n1) o_len = LEN_W'(3) + LEN_W'(i_n1);
      end
      OP_GOTO, OP_GOSUB: begin
        o_len   = LEN_W'(4);
        o_class = CLS_JUMP;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/saturn_ins_framer.sv
// rtl/saturn_ins_framer.sv - collects variable-length nibble instructions for execute
// Collection of the next instruction overlaps a held output; only its last nibble waits.
module saturn_ins_framer
  import saturn_pkg::*;
#(
  parameter int MAX_NIBBLES = 18,
  parameter int ADDR_W      = 20,
  parameter int LEN_W       = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en_dec,
  input  logic                     i_stalled,
  input  logic [ADDR_W-1:0]        i_pc,
  input  logic [3:0]               i_nibble,
  output logic                     o_inc_pc,
  output logic                     o_ins_valid,
  input  logic                     i_ins_ready,
  output logic [ADDR_W-1:0]        o_ins_addr,
  output logic [LEN_W-1:0]         o_ins_len,
  output ins_class_e               o_ins_class,
  output logic [4*MAX_NIBBLES-1:0] o_ins_nibs,
  output logic                     o_dec_error
);

  frm_state_e                  state_q, state_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [LEN_W-1:0]            len_q, len_d;
  ins_class_e                  cls_q, cls_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [MAX_NIBBLES-1:0][3:0] buf_q, buf_d;

  logic                        valid_q, valid_d;
  logic [ADDR_W-1:0]           out_addr_q, out_addr_d;
  logic [LEN_W-1:0]            out_len_q, out_len_d;
  ins_class_e                  out_cls_q, out_cls_d;
  logic [MAX_NIBBLES-1:0][3:0] out_nibs_q, out_nibs_d;
  logic                        err_q, err_d;

  logic [3:0]       dec_n0;
  logic             dec_have_n1;
  logic [LEN_W-1:0] dec_len;
  ins_class_e       dec_class;
  logic             dec_illegal;

  logic [LEN_W-1:0] tgt_len;
  ins_class_e       tgt_cls;
  logic             bad_nib;
  logic             final_nib;
  logic             acc;

  assign dec_n0      = (state_q == S_FIRST) ? i_nibble : buf_q[0];
  assign dec_have_n1 = (state_q == S_COLLECT) && (cnt_q == LEN_W'(1));

  saturn_ins_len #(
    .LEN_W(LEN_W)
  ) u_len (
    .i_n0      (dec_n0),
    .i_n1      (i_nibble),
    .i_have_n1 (dec_have_n1),
    .o_len     (dec_len),
    .o_class   (dec_class),
    .o_illegal (dec_illegal)
  );

  // The target length is only trusted from the second nibble onward.
  assign tgt_len   = dec_have_n1 ? dec_len : len_q;
  assign tgt_cls   = dec_have_n1 ? dec_class : cls_q;
  assign bad_nib   = (state_q == S_FIRST) ? dec_illegal
                   : (dec_have_n1 && (dec_illegal || (dec_len > LEN_W'(MAX_NIBBLES))));
  assign final_nib = (state_q == S_COLLECT) && !bad_nib && ((cnt_q + LEN_W'(1)) == tgt_len);

  assign acc = i_reset & i_en_dec & ~i_stalled & ~err_q
             & ~(valid_q & ~i_ins_ready & final_nib);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    cls_d      = cls_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    valid_d    = valid_q;
    out_addr_d = out_addr_q;
    out_len_d  = out_len_q;
    out_cls_d  = out_cls_q;
    out_nibs_d = out_nibs_q;
    err_d      = err_q;

    if (!i_stalled && valid_q && i_ins_ready) valid_d = 1'b0;

    if (acc) begin
      case (state_q)
        S_FIRST: begin
          addr_d   = i_pc;
          buf_d    = '0;
          buf_d[0] = i_nibble;
          cnt_d    = LEN_W'(1);
          if (bad_nib) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          buf_d[cnt_q] = i_nibble;
          cnt_d        = cnt_q + LEN_W'(1);
          if (dec_have_n1) begin
            len_d = dec_len;
            cls_d = dec_class;
          end
          if (bad_nib) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (final_nib) begin
            state_d    = S_FIRST;
            cnt_d      = '0;
            valid_d    = 1'b1;
            out_addr_d = addr_q;
            out_len_d  = tgt_len;
            out_cls_d  = tgt_cls;
            out_nibs_d = buf_d;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_FIRST;
      cnt_q      <= '0;
      len_q      <= '0;
      cls_q      <= CLS_NONE;
      addr_q     <= '0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_len_q  <= '0;
      out_cls_q  <= CLS_NONE;
      out_nibs_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      cls_q      <= cls_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      out_addr_q <= out_addr_d;
      out_len_q  <= out_len_d;
      out_cls_q  <= out_cls_d;
      out_nibs_q <= out_nibs_d;
      err_q      <= err_d;
    end
  end

  assign o_inc_pc    = acc;
  assign o_ins_valid = valid_q;
  assign o_ins_addr  = out_addr_q;
  assign o_ins_len   = out_len_q;
  assign o_ins_class = out_cls_q;
  assign o_ins_nibs  = out_nibs_q;
  assign o_dec_error = err_q;

endmodule

// File: tb/tb_saturn_ins_framer.sv
// tb/tb_saturn_ins_framer.sv - self-checking bench for saturn_ins_framer
module tb_saturn_ins_framer;
  import saturn_pkg::*;

  localparam int MAXN = 18;
  localparam int AW   = 20;
  localparam int LW   = 5;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_en_dec = 1'b0;
  logic              i_stalled = 1'b0;
  logic [AW-1:0]     i_pc = '0;
  logic [3:0]        i_nibble = '0;
  logic              i_ins_ready = 1'b0;
  logic              o_inc_pc;
  logic              o_ins_valid;
  logic [AW-1:0]     o_ins_addr;
  logic [LW-1:0]     o_ins_len;
  ins_class_e        o_ins_class;
  logic [4*MAXN-1:0] o_ins_nibs;
  logic              o_dec_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0]     addr;
    int                len;
    ins_class_e        cls;
    logic [4*MAXN-1:0] nibs;
  } ins_t;

  always #5 i_clk = ~i_clk;

  saturn_ins_framer #(
    .MAX_NIBBLES(MAXN),
    .ADDR_W     (AW),
    .LEN_W      (LW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en_dec    (i_en_dec),
    .i_stalled   (i_stalled),
    .i_pc        (i_pc),
    .i_nibble    (i_nibble),
    .o_inc_pc    (o_inc_pc),
    .o_ins_valid (o_ins_valid),
    .i_ins_ready (i_ins_ready),
    .o_ins_addr  (o_ins_addr),
    .o_ins_len   (o_ins_len),
    .o_ins_class (o_ins_class),
    .o_ins_nibs  (o_ins_nibs),
    .o_dec_error (o_dec_error)
  );

  function automatic int ref_len(input logic [3:0] n0, input logic [3:0] n1);
    if (n0 == 4'h0) return (n1 == 4'hE) ? 4 : 2;
    if (n0 == 4'h2) return 2;
    if (n0 == 4'h3) return 3 + int'(n1);
    return 4;
  endfunction

  function automatic ins_class_e ref_class(input logic [3:0] n0, input logic [3:0] n1);
    if (n0 == 4'h0) begin
      if (n1 == 4'hE) return CLS_EXT;
      if (n1 < 4'h4) return CLS_RTN;
      if (n1 < 4'h6) return CLS_MODE;
      return CLS_RSTK;
    end
    if (n0 == 4'h2) return CLS_PTR;
    if (n0 == 4'h3) return CLS_LC;
    return CLS_JUMP;
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] nib, input logic [AW-1:0] pc,
                       input logic rdy, input logic stl);
    i_en_dec    = en;
    i_nibble    = nib;
    i_pc        = pc;
    i_ins_ready = rdy;
    i_stalled   = stl;
    #1;
  endtask

  task automatic apply_reset;
    i_reset = 1'b0;
    drive(1'b0, 4'h0, '0, 1'b0, 1'b0);
    tick;
    i_reset = 1'b1;
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    drive(1'b1, 4'h3, 20'h00055, 1'b1, 1'b0);
    checks++;
    if (o_inc_pc !== 1'b0) begin
      failures++;
      $display("FAIL reset_inc_pc got=%0b want=0", o_inc_pc);
    end
    tick;
    tick;
    checks++;
    if ({o_ins_valid, o_dec_error, o_ins_len, o_ins_addr} !== '0 || o_ins_class !== CLS_NONE) begin
      failures++;
      $display("FAIL reset_fields valid=%0b err=%0b len=%0d addr=%h cls=%0d want all 0",
               o_ins_valid, o_dec_error, o_ins_len, o_ins_addr, o_ins_class);
    end
    checks++;
    if (o_ins_nibs !== '0) begin
      failures++;
      $display("FAIL reset_nibs got=%h want=0", o_ins_nibs);
    end
    i_reset = 1'b1;
    drive(1'b0, 4'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_rtn;
    apply_reset;
    drive(1'b1, 4'h0, 20'h01000, 1'b1, 1'b0);
    checks++;
    if (o_inc_pc !== 1'b1) begin
      failures++;
      $display("FAIL rtn_inc0 got=%0b want=1", o_inc_pc);
    end
    tick;
    checks++;
    if (o_ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL rtn_early_valid got=%0b want=0", o_ins_valid);
    end
    drive(1'b1, 4'h1, 20'h01001, 1'b1, 1'b0);
    tick;
    checks++;
    if (o_ins_valid !== 1'b1 || o_ins_len !== 5'd2 || o_ins_class !== CLS_RTN ||
        o_ins_addr !== 20'h01000 || o_ins_nibs !== 72'h10) begin
      failures++;
      $display("FAIL rtn_out valid=%0b len=%0d cls=%0d addr=%h nibs=%h want 1/2/%0d/01000/10",
               o_ins_valid, o_ins_len, o_ins_class, o_ins_addr, o_ins_nibs, CLS_RTN);
    end
    drive(1'b0, 4'h0, '0, 1'b1, 1'b0);
    tick;
    checks++;
    if (o_ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL rtn_drop got=%0b want=0", o_ins_valid);
    end
  endtask

  task automatic test_lc;
    logic [4*MAXN-1:0] exp;
    int inc_bad;
    apply_reset;
    exp = '0;
    exp[3:0] = 4'h3;
    exp[7:4] = 4'hF;
    for (int k = 0; k < 16; k++) exp[8+4*k +: 4] = 4'($urandom);
    inc_bad = 0;
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, exp[4*k +: 4], 20'h0A000 + AW'(k), 1'b1, 1'b0);
      checks++;
      if (o_inc_pc !== 1'b1) begin
        failures++;
        $display("FAIL lc_inc nibble=%0d got=%0b want=1", k, o_inc_pc);
      end
      tick;
    end
    checks++;
    if (o_ins_valid !== 1'b1 || o_ins_len !== 5'd18 || o_ins_class !== CLS_LC ||
        o_ins_addr !== 20'h0A000) begin
      failures++;
      $display("FAIL lc_hdr valid=%0b len=%0d cls=%0d addr=%h want 1/18/%0d/0a000",
               o_ins_valid, o_ins_len, o_ins_class, o_ins_addr, CLS_LC);
    end
    checks++;
    if (o_ins_nibs !== exp) begin
      failures++;
      $display("FAIL lc_data got=%h want=%h", o_ins_nibs, exp);
    end
    drive(1'b0, 4'h0, '0, 1'b1, 1'b0);
    tick;
  endtask

  task automatic test_back_to_back;
    logic [3:0] seq [6];
    seq = '{4'h2, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC};
    apply_reset;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, seq[k], 20'h00200 + AW'(k), 1'b0, 1'b0);
      checks++;
      if (o_inc_pc !== 1'b1) begin
        failures++;
        $display("FAIL b2b_inc nibble=%0d got=%0b want=1", k, o_inc_pc);
      end
      tick;
      if (k >= 1) begin
        checks++;
        if (o_ins_valid !== 1'b1 || o_ins_class !== CLS_PTR || o_ins_addr !== 20'h00200 ||
            o_ins_nibs !== 72'h52) begin
          failures++;
          $display("FAIL b2b_first_hold k=%0d valid=%0b cls=%0d addr=%h nibs=%h want 1/%0d/00200/52",
                   k, o_ins_valid, o_ins_class, o_ins_addr, o_ins_nibs, CLS_PTR);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, seq[5], 20'h00205, 1'b0, 1'b0);
      checks++;
      if (o_inc_pc !== 1'b0) begin
        failures++;
        $display("FAIL b2b_final_wait cycle=%0d got=%0b want=0", c, o_inc_pc);
      end
      tick;
      checks++;
      if (o_ins_valid !== 1'b1 || o_ins_len !== 5'd2 || o_ins_addr !== 20'h00200) begin
        failures++;
        $display("FAIL b2b_held cycle=%0d valid=%0b len=%0d addr=%h want 1/2/00200",
                 c, o_ins_valid, o_ins_len, o_ins_addr);
      end
    end
    drive(1'b1, seq[5], 20'h00205, 1'b1, 1'b0);
    checks++;
    if (o_inc_pc !== 1'b1) begin
      failures++;
      $display("FAIL b2b_final_go got=%0b want=1", o_inc_pc);
    end
    tick;
    checks++;
    if (o_ins_valid !== 1'b1 || o_ins_len !== 5'd4 || o_ins_class !== CLS_JUMP ||
        o_ins_addr !== 20'h00202 || o_ins_nibs !== 72'hCBA6) begin
      failures++;
      $display("FAIL b2b_second valid=%0b len=%0d cls=%0d addr=%h nibs=%h want 1/4/%0d/00202/cba6",
               o_ins_valid, o_ins_len, o_ins_class, o_ins_addr, o_ins_nibs, CLS_JUMP);
    end
    drive(1'b0, 4'h0, '0, 1'b1, 1'b0);
    tick;
    checks++;
    if (o_ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drop got=%0b want=0", o_ins_valid);
    end
  endtask

  task automatic test_error;
    apply_reset;
    drive(1'b1, 4'h2, 20'h00300, 1'b0, 1'b0);
    tick;
    drive(1'b1, 4'h7, 20'h00301, 1'b0, 1'b0);
    tick;
    drive(1'b1, 4'h9, 20'h00302, 1'b0, 1'b0);
    checks++;
    if (o_inc_pc !== 1'b1) begin
      failures++;
      $display("FAIL err_first_acc got=%0b want=1", o_inc_pc);
    end
    tick;
    checks++;
    if (o_dec_error !== 1'b1 || o_ins_valid !== 1'b1) begin
      failures++;
      $display("FAIL err_set err=%0b valid=%0b want 1/1", o_dec_error, o_ins_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'h0, 20'h00303, 1'b1, 1'b0);
      checks++;
      if (o_inc_pc !== 1'b0 || o_dec_error !== 1'b1) begin
        failures++;
        $display("FAIL err_hold cycle=%0d inc=%0b err=%0b want 0/1", c, o_inc_pc, o_dec_error);
      end
      tick;
    end
    i_reset = 1'b0;
    tick;
    i_reset = 1'b1;
    drive(1'b0, 4'h0, '0, 1'b0, 1'b0);
    checks++;
    if ({o_inc_pc, o_ins_valid, o_dec_error, o_ins_len, o_ins_addr} !== '0 ||
        o_ins_class !== CLS_NONE || o_ins_nibs !== '0) begin
      failures++;
      $display("FAIL err_reset inc=%0b valid=%0b err=%0b len=%0d addr=%h cls=%0d nibs=%h want all 0",
               o_inc_pc, o_ins_valid, o_dec_error, o_ins_len, o_ins_addr, o_ins_class, o_ins_nibs);
    end
  endtask

  task automatic test_stall;
    apply_reset;
    drive(1'b1, 4'h6, 20'h00400, 1'b1, 1'b0);
    tick;
    drive(1'b1, 4'h1, 20'h00401, 1'b1, 1'b0);
    tick;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'h2, 20'h00402, 1'b1, 1'b1);
      checks++;
      if (o_inc_pc !== 1'b0) begin
        failures++;
        $display("FAIL stall_inc cycle=%0d got=%0b want=0", c, o_inc_pc);
      end
      tick;
      checks++;
      if (o_ins_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_valid cycle=%0d got=%0b want=0", c, o_ins_valid);
      end
    end
    drive(1'b1, 4'h2, 20'h00402, 1'b1, 1'b0);
    tick;
    drive(1'b1, 4'h3, 20'h00403, 1'b1, 1'b0);
    tick;
    checks++;
    if (o_ins_valid !== 1'b1 || o_ins_len !== 5'd4 || o_ins_class !== CLS_JUMP ||
        o_ins_addr !== 20'h00400 || o_ins_nibs !== 72'h3216) begin
      failures++;
      $display("FAIL stall_done valid=%0b len=%0d cls=%0d addr=%h nibs=%h want 1/4/%0d/00400/3216",
               o_ins_valid, o_ins_len, o_ins_class, o_ins_addr, o_ins_nibs, CLS_JUMP);
    end
    drive(1'b0, 4'h0, '0, 1'b1, 1'b1);
    tick;
    tick;
    checks++;
    if (o_ins_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_handshake_frozen got=%0b want=1", o_ins_valid);
    end
    drive(1'b0, 4'h0, '0, 1'b1, 1'b0);
    tick;
    checks++;
    if (o_ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release_drop got=%0b want=0", o_ins_valid);
    end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    drive(1'b1, 4'h0, 20'h00500, 1'b1, 1'b0);
    tick;
    drive(1'b1, 4'hE, 20'h00501, 1'b1, 1'b0);
    tick;
    drive(1'b1, 4'h5, 20'h00502, 1'b1, 1'b0);
    tick;
    i_reset = 1'b0;
    tick;
    i_reset = 1'b1;
    drive(1'b1, 4'h0, 20'h00600, 1'b1, 1'b0);
    tick;
    drive(1'b1, 4'h4, 20'h00601, 1'b1, 1'b0);
    tick;
    checks++;
    if (o_ins_valid !== 1'b1 || o_ins_len !== 5'd2 || o_ins_class !== CLS_MODE ||
        o_ins_addr !== 20'h00600 || o_ins_nibs !== 72'h40) begin
      failures++;
      $display("FAIL reset_mid valid=%0b len=%0d cls=%0d addr=%h nibs=%h want 1/2/%0d/00600/40",
               o_ins_valid, o_ins_len, o_ins_class, o_ins_addr, o_ins_nibs, CLS_MODE);
    end
    drive(1'b0, 4'h0, '0, 1'b1, 1'b0);
    tick;
  endtask

  task automatic test_random(input int trials);
    for (int t = 0; t < trials; t++) begin
      logic [3:0]    nib_q[$];
      logic [AW-1:0] pc_q[$];
      bit            last_q[$];
      int            own_q[$];
      ins_t          ins_q[$];
      ins_t          e;
      logic [AW-1:0] pc;
      logic [3:0]    n0, n1, nb;
      int            n_ins, pos, m_idx, done, cyc;
      bit            m_valid, en, rdy, stl, is_last, exp_acc;

      apply_reset;
      pc    = AW'($urandom);
      n_ins = 10 + int'($urandom_range(0, 9));
      for (int i = 0; i < n_ins; i++) begin
        n1 = 4'($urandom);
        case ($urandom_range(0, 4))
          0: begin
            n0 = 4'h0;
            n1 = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 7));
          end
          1: n0 = 4'h2;
          2: n0 = 4'h3;
          3: n0 = 4'h6;
          default: n0 = 4'h7;
        endcase
        e.addr = pc;
        e.len  = ref_len(n0, n1);
        e.cls  = ref_class(n0, n1);
        e.nibs = '0;
        for (int k = 0; k < e.len; k++) begin
          nb = (k == 0) ? n0 : (k == 1) ? n1 : 4'($urandom);
          e.nibs[4*k +: 4] = nb;
          nib_q.push_back(nb);
          pc_q.push_back(pc);
          last_q.push_back(k == e.len - 1);
          own_q.push_back(i);
          pc = pc + 1'b1;
        end
        ins_q.push_back(e);
      end

      pos = 0; m_idx = 0; done = 0; cyc = 0; m_valid = 0;
      while (done < n_ins && cyc < 4000) begin
        en  = ($urandom_range(0, 3) != 0) && (pos < nib_q.size());
        rdy = $urandom_range(0, 1) == 1;
        stl = $urandom_range(0, 7) == 0;
        is_last = en ? last_q[pos] : 1'b0;
        drive(en, en ? nib_q[pos] : 4'h0, en ? pc_q[pos] : '0, rdy, stl);
        exp_acc = en && !stl && !(m_valid && !rdy && is_last);
        checks++;
        if (o_inc_pc !== exp_acc) begin
          failures++;
          $display("FAIL rnd_inc trial=%0d cyc=%0d got=%0b want=%0b", t, cyc, o_inc_pc, exp_acc);
        end
        checks++;
        if (o_ins_valid !== m_valid) begin
          failures++;
          $display("FAIL rnd_valid trial=%0d cyc=%0d got=%0b want=%0b", t, cyc, o_ins_valid, m_valid);
        end
        if (m_valid) begin
          e = ins_q[m_idx];
          checks++;
          if (o_ins_addr !== e.addr || o_ins_len !== LW'(e.len) || o_ins_class !== e.cls ||
              o_ins_nibs !== e.nibs) begin
            failures++;
            $display("FAIL rnd_fields trial=%0d ins=%0d addr=%h/%h len=%0d/%0d cls=%0d/%0d nibs=%h/%h",
                     t, m_idx, o_ins_addr, e.addr, o_ins_len, e.len, o_ins_class, e.cls,
                     o_ins_nibs, e.nibs);
          end
        end
        if (!stl) begin
          if (m_valid && rdy) begin
            m_valid = 0;
            done++;
          end
          if (exp_acc) begin
            if (is_last) begin
              m_valid = 1;
              m_idx   = own_q[pos];
            end
            pos++;
          end
        end
        tick;
        cyc++;
      end
      checks++;
      if (done != n_ins || o_dec_error !== 1'b0) begin
        failures++;
        $display("FAIL rnd_complete trial=%0d delivered=%0d want=%0d err=%0b", t, done, n_ins, o_dec_error);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rtn;
    test_lc;
    test_back_to_back;
    test_error;
    test_stall;
    test_reset_mid;
    test_random(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
